display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for the board's common-anode 7-segment displays. It replaces fixed-clock two-way digit selection with a counter-driven scheduler: one digit is lit at a time, a blanking gap is inserted between digits to suppress ghosting, and digit data is latched once per frame so values do not tear mid-scan. It sits between the game/control logic, which supplies decoded segment patterns, and the display pins.

## Interface
- NUM_DIGITS, 2: number of multiplexed digits, 2..8.
- SLOT_CYCLES, 390625: clock cycles per digit slot, including blanking. The default gives a 64 Hz frame at 50 MHz with 2 digits.
- BLANK_CYCLES, 1000: dark cycles at the start of each slot. Must be less than SLOT_CYCLES.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; low forces the display dark.
- digit_data  input  7*NUM_DIGITS  segment patterns, active-low; digit i occupies bits [7*i+6:7*i].
- seg  output  7  segment drive, active-low, registered.
- an  output  NUM_DIGITS  anode select, active-low, one-cold, registered.
- digit_idx  output  clog2(NUM_DIGITS)  index of the digit currently in its slot.
- frame_start  output  1  one-cycle pulse when the slot of digit 0 begins.

## Operation
- States:
  - OFF: an all ones, seg all ones.
  - BLANK: an all ones, seg all ones.
  - SHOW: an[digit_idx]=0, seg = latched slice for digit_idx.
- Transitions:
  - OFF→BLANK when en=1. At that point digit_idx=0, digit_data is latched into the frame buffer, frame_start pulses, and the slot counter is cleared.
  - BLANK→SHOW when the slot counter reaches BLANK_CYCLES-1.
  - SHOW→BLANK when the slot counter reaches SLOT_CYCLES-1. digit_idx then increments.
  - Wrap-around: when digit_idx=NUM_DIGITS-1 the next digit is 0. On that wrap the frame buffer is relatched and frame_start pulses.
  - Any state→OFF on the cycle after en is sampled low. digit_idx is reset to 0 and the slot counter is cleared. Re-enabling always restarts at digit 0 with a fresh latch.
- digit_data changes mid-frame have no effect until the next frame latch.
- Slot counter width: clog2(SLOT_CYCLES). It never exceeds SLOT_CYCLES-1.
- an is never driven with more than one zero. Two digits are never lit in the same cycle.

## Timing
- Reset values: seg=all ones, an=all ones, digit_idx=0, frame_start=0, state OFF, frame buffer all ones.
- Outputs are registered. Say en is first sampled high on the rising edge of cycle k:
  - frame_start=1 during cycle k+1.
  - Digit 0 lights at cycle k+1+BLANK_CYCLES.
- Each digit is lit for exactly SLOT_CYCLES-BLANK_CYCLES cycles.
- Frame period is NUM_DIGITS*SLOT_CYCLES cycles. frame_start is periodic with that period while en=1.
- en low: seg and an are dark one cycle after en is sampled low.
- Reset asserted mid-scan: outputs go dark immediately (asynchronously). Scanning resumes from OFF after release.

## Configuration
- DISPLAY_SCAN_BLANK_EN defined:
  - BLANK state present, as described above.
- DISPLAY_SCAN_BLANK_EN not defined:
  - BLANK state is compiled out and BLANK_CYCLES is ignored.
  - OFF→SHOW directly, and SHOW→SHOW at each slot end with the next digit_idx.
  - Each digit is lit for SLOT_CYCLES cycles.
  - Digit 0 lights at cycle k+1, in the same cycle as frame_start.

## Structure
- Shared package display_pkg:
  - SEG_BLANK constant (7'h7F).
  - Scan-state enum (OFF, BLANK, SHOW).
  - clog2 helper.
- Sub-module scan_timer: parameterised slot counter with clear input and terminal-count outputs (blank_done, slot_done).
- The FSM and output registers stay in display_scan_ctrl.

## Test plan
Bench parameters for all scenarios: NUM_DIGITS=2, SLOT_CYCLES=6, BLANK_CYCLES=2, macro defined unless stated.
- Reset check: rst_n=0 then release with en=0 → seg=7'h7F and an=2'b11 for 20 cycles, and frame_start stays 0.
- Basic scan: digit_data={7'h24,7'h79}, en=1 → per 6-cycle slot, 2 dark cycles then 4 lit cycles.
  - Slot 0: an=2'b10 with seg=7'h79.
  - Slot 1: an=2'b01 with seg=7'h24.
  - frame_start pulses every 12 cycles.
- Frame latch: change digit_data during slot 1 → the new value appears on seg only after the next frame_start.
- Disable mid-scan: drop en during SHOW of digit 1 → dark on the next cycle. Re-raise en → frame_start pulses and digit 0 is shown first.
- Async reset mid-scan: pulse rst_n low for half a cycle during SHOW → an=2'b11 with no clock edge, and the state returns to OFF.
- Macro undefined: same stimulus as basic scan → no dark cycles, each digit lit for 6 cycles, and an is always one-cold while en=1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan controller: blank pattern,
// scan-state encoding and a constant-safe ceil(log2) helper.
package display_pkg;

    // Active-low segments: all ones means every segment is off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Ceil(log2(value)), never less than 1 so a single-value range still
    // gets a one-bit signal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Slot counter for the scan controller. Counts 0..SLOT_CYCLES-1 and wraps,
// with a synchronous clear; flags the last blank cycle and the last slot cycle.
module scan_timer
    import display_pkg::*;
#(
    parameter int SLOT_CYCLES  = 390625,
    parameter int BLANK_CYCLES = 1000,
    localparam int CNT_W       = clog2(SLOT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic blank_done,
    output logic slot_done
);

    logic [CNT_W-1:0] count;

    assign slot_done  = (count == CNT_W'(SLOT_CYCLES - 1));
    assign blank_done = (count == CNT_W'(BLANK_CYCLES - 1));

    // Free-running slot counter; wraps at the slot end so it never passes SLOT_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || slot_done) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// One digit lit at a time, optional dark gap at the start of each slot,
// digit data latched once per frame so a scan never tears.
// Build option: DISPLAY_SCAN_BLANK_EN enables the BLANK gap; without it
// each digit is lit for the whole slot and BLANK_CYCLES is ignored.
// Handshake: none; en is a level, frame_start is a one-cycle strobe.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int SLOT_CYCLES  = 390625,
    parameter int BLANK_CYCLES = 1000,
    localparam int IDX_W       = clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [7*NUM_DIGITS-1:0] digit_data,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state, next_state;
    logic [IDX_W-1:0]        idx_next;
    logic [7*NUM_DIGITS-1:0] frame_q, frame_next;
    logic                    fs_next;
    logic                    clear;
    logic                    blank_done, slot_done;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    scan_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

`ifndef DISPLAY_SCAN_BLANK_EN
    // Without the gap the blank terminal count has no consumer.
    logic unused_blank_done;
    assign unused_blank_done = blank_done;
`endif

    // Next-state, next digit, frame relatch and frame_start decisions.
    always_comb begin
        next_state = state;
        idx_next   = digit_idx;
        frame_next = frame_q;
        fs_next    = 1'b0;
        clear      = 1'b0;
        if (!en) begin
            next_state = OFF;
            idx_next   = '0;
            clear      = 1'b1;
        end else begin
            case (state)
                OFF: begin
`ifdef DISPLAY_SCAN_BLANK_EN
                    next_state = BLANK;
`else
                    next_state = SHOW;
`endif
                    idx_next   = '0;
                    frame_next = digit_data;
                    fs_next    = 1'b1;
                    clear      = 1'b1;
                end
`ifdef DISPLAY_SCAN_BLANK_EN
                BLANK: begin
                    if (blank_done) next_state = SHOW;
                end
`endif
                SHOW: begin
                    if (slot_done) begin
`ifdef DISPLAY_SCAN_BLANK_EN
                        next_state = BLANK;
`else
                        next_state = SHOW;
`endif
                        if (digit_idx == LAST_IDX) begin
                            idx_next   = '0;
                            frame_next = digit_data;
                            fs_next    = 1'b1;
                        end else begin
                            idx_next = digit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    next_state = OFF;
                    idx_next   = '0;
                    clear      = 1'b1;
                end
            endcase
        end
    end

    // Pin values for the coming cycle, derived from the coming state so outputs stay registered.
    always_comb begin
        an_next  = '1;
        seg_next = SEG_BLANK;
        if (next_state == SHOW) begin
            an_next[idx_next] = 1'b0;
            seg_next          = frame_next[int'(idx_next)*7 +: 7];
        end
    end

    // State, frame buffer and output registers; reset forces the display dark at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            digit_idx   <= '0;
            frame_q     <= '1;
            frame_start <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= '1;
        end else begin
            state       <= next_state;
            digit_idx   <= idx_next;
            frame_q     <= frame_next;
            frame_start <= fs_next;
            seg         <= seg_next;
            an          <= an_next;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with NUM_DIGITS=2, SLOT_CYCLES=6, BLANK_CYCLES=2.
// Works with DISPLAY_SCAN_BLANK_EN defined or not.
module tb_display_scan_ctrl;

    localparam int NUM_DIGITS   = 2;
    localparam int SLOT_CYCLES  = 6;
    localparam int BLANK_CYCLES = 2;
`ifdef DISPLAY_SCAN_BLANK_EN
    localparam int EFF_BLANK = BLANK_CYCLES;
`else
    localparam int EFF_BLANK = 0;
`endif
    localparam int FRAME = NUM_DIGITS * SLOT_CYCLES;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [13:0] digit_data = '1;
    logic [6:0]  seg;
    logic [1:0]  an;
    logic [0:0]  digit_idx;
    logic        frame_start;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digit_data  (digit_data),
        .seg         (seg),
        .an          (an),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    // ---------------- reference model ----------------
    // m_t is the cycle position inside the current frame since scanning began;
    // slot = m_t / SLOT_CYCLES, dark for the first EFF_BLANK cycles of a slot.
    bit          m_run = 1'b0;
    int          m_t = 0;
    logic [13:0] m_snap = '1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0;
            m_t   = 0;
            m_snap = '1;
        end else if (!en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_t    = 0;
            m_snap = digit_data;
        end else begin
            m_t = m_t + 1;
            if (m_t == FRAME) begin
                m_t    = 0;
                m_snap = digit_data;
            end
        end
    end

    function automatic bit exp_lit();
        return m_run && ((m_t % SLOT_CYCLES) >= EFF_BLANK);
    endfunction

    function automatic logic [1:0] exp_an();
        logic [1:0] v;
        v = 2'b11;
        if (exp_lit()) v[m_t / SLOT_CYCLES] = 1'b0;
        return v;
    endfunction

    function automatic logic [6:0] exp_seg();
        logic [6:0] v;
        v = 7'h7F;
        if (exp_lit()) v = m_snap[(m_t / SLOT_CYCLES) * 7 +: 7];
        return v;
    endfunction

    function automatic int exp_idx();
        return m_run ? (m_t / SLOT_CYCLES) : 0;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    // Advance to the next falling edge and compare every output with the model.
    task automatic step();
        @(negedge clk);
        check("seg", 32'(seg), 32'(exp_seg()));
        check("an", 32'(an), 32'(exp_an()));
        check("digit_idx", 32'(digit_idx), 32'(exp_idx()));
        check("frame_start", 32'(frame_start), 32'(m_run && m_t == 0));
        check("an_onecold", 32'($countones(~an) <= 1), 32'd1);
    endtask

    // Run until digit d is lit, bounded; a miss counts as a failure.
    task automatic wait_show(input int d);
        int n;
        n = 0;
        while (!(exp_lit() && (m_t / SLOT_CYCLES) == d) && n < 3 * FRAME) begin
            step();
            n++;
        end
        check("wait_show_timeout", 32'(exp_lit() && (m_t / SLOT_CYCLES) == d), 32'd1);
    endtask

    // Pulse reset low for half a cycle between clock edges.
    task automatic async_reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'h3);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_fs", 32'(frame_start), 32'h0);
        #4 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        digit_data = '1;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'h3);
        check("rst_idx", 32'(digit_idx), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        rst_n = 1'b1;
        repeat (20) step();

        // Basic scan with the fixed pattern.
        digit_data = {7'h24, 7'h79};
        en = 1'b1;
        step();
        check("basic_first_fs", 32'(frame_start), 32'h1);
        repeat (2 * FRAME + 2) step();

        // Change data while digit 1 is shown; must not appear before next frame.
        wait_show(1);
        digit_data = {7'h12, 7'h40};
        step();
        check("latch_hold_seg", 32'(seg), 32'h24);
        repeat (FRAME + 2) step();

        // Disable while digit 1 is shown, then re-enable.
        wait_show(1);
        en = 1'b0;
        step();
        check("dis_an", 32'(an), 32'h3);
        check("dis_seg", 32'(seg), 32'h7F);
        en = 1'b1;
        step();
        check("reen_fs", 32'(frame_start), 32'h1);
        repeat (EFF_BLANK) step();
        check("reen_an", 32'(an), 32'h2);
        check("reen_seg", 32'(seg), 32'h40);
        repeat (FRAME) step();

        // Asynchronous reset while a digit is shown.
        wait_show(0);
        async_reset_pulse();
        repeat (FRAME + 3) step();

        // Randomised data changes and enable drops.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) digit_data = 14'($urandom);
            en = ($urandom_range(0, 24) != 0);
            step();
        end

        en = 1'b1;
        repeat (2 * FRAME) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
